// File: rtl/maxicore32_exec_unit.sv
// MaxiCore32 execution/memory unit: combinational AGU, registered ALU with NZCV,
// and a big-endian bus interface with lane strobes and alignment checking.
module maxicore32_exec_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] agu_base_address,
    input  logic        agu_immediate_mode,
    input  logic [15:0] agu_immediate,
    input  logic [31:0] agu_register_data,
    output logic [31:0] agu_result,
    input  logic [4:0]  alu_op,
    input  logic [31:0] alu_reg2,
    input  logic [31:0] alu_reg3,
    input  logic        alu_carry_in,
    output logic [31:0] alu_result,
    output logic        alu_carry_out,
    output logic        alu_zero_out,
    output logic        alu_neg_out,
    output logic        alu_over_out,
    input  logic [31:0] cpu_address,
    input  logic [1:0]  cpu_cycle_width,
    input  logic [31:0] cpu_data_out,
    output logic [31:0] cpu_data_in,
    input  logic        cpu_read,
    input  logic        cpu_write,
    output logic [29:0] bus_address,
    input  logic [31:0] bus_data_in,
    output logic [31:0] bus_data_out,
    output logic [3:0]  bus_data_strobes,
    output logic        bus_read,
    output logic        bus_write,
    output logic        bus_error
);

    typedef enum logic [4:0] {
        OP_ADD  = 5'b00000, OP_ADDC = 5'b00001, OP_SUB  = 5'b00010,
        OP_SUBC = 5'b00011, OP_AND  = 5'b00100, OP_OR   = 5'b00101,
        OP_XOR  = 5'b00110, OP_NOT  = 5'b00111, OP_LSL  = 5'b01000,
        OP_LSR  = 5'b01001, OP_ASR  = 5'b01010, OP_COPY = 5'b01011,
        OP_NEG  = 5'b01100, OP_PASS = 5'b11111
    } alu_op_e;

    typedef enum logic [1:0] {
        WIDTH_BYTE = 2'b00, WIDTH_WORD = 2'b01, WIDTH_LONG = 2'b10, WIDTH_RSVD = 2'b11
    } cycle_width_e;

    // ---------------- AGU ----------------
    assign agu_result = agu_base_address +
                        (agu_immediate_mode ? {{16{agu_immediate[15]}}, agu_immediate}
                                            : agu_register_data);

    // ---------------- ALU ----------------
    logic [31:0]        op_a, op_b, minuend;
    logic [4:0]         shift_count;
    logic               carry_sel, borrow_sel;
    logic [32:0]        sum_ext, diff_ext, lsl_ext, lsr_ext;
    logic signed [32:0] asr_ext;
    logic [31:0]        next_result;
    logic               next_carry, next_over;

    assign op_a        = alu_reg2;
    assign op_b        = alu_reg3;
    assign shift_count = op_b[4:0];
    assign minuend     = (alu_op == OP_NEG) ? 32'd0 : op_a;
    assign carry_sel   = (alu_op == OP_ADDC) & alu_carry_in;
    assign borrow_sel  = (alu_op == OP_SUBC) & alu_carry_in;

    // Bit 32 of the 33-bit difference is the borrow: set when minuend < subtrahend + borrow-in.
    assign sum_ext  = {1'b0, op_a} + {1'b0, op_b} + {32'd0, carry_sel};
    assign diff_ext = {1'b0, minuend} - {1'b0, op_b} - {32'd0, borrow_sel};

    // Shifts carry one guard bit so the last bit out lands there; a zero count leaves it 0.
    assign lsl_ext = {1'b0, op_a} << shift_count;
    assign lsr_ext = {op_a, 1'b0} >> shift_count;
    assign asr_ext = $signed({op_a, 1'b0}) >>> shift_count;

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        next_result = '0;
        next_carry  = 1'b0;
        next_over   = 1'b0;
        case (alu_op)
            OP_ADD, OP_ADDC: begin
                next_result = sum_ext[31:0];
                next_carry  = sum_ext[32];
                next_over   = (op_a[31] == op_b[31]) && (sum_ext[31] != op_a[31]);
            end
            OP_SUB, OP_SUBC, OP_NEG: begin
                next_result = diff_ext[31:0];
                next_carry  = diff_ext[32];
                next_over   = (minuend[31] != op_b[31]) && (diff_ext[31] != minuend[31]);
            end
            OP_AND:  next_result = op_a & op_b;
            OP_OR:   next_result = op_a | op_b;
            OP_XOR:  next_result = op_a ^ op_b;
            OP_NOT:  next_result = ~op_b;
            OP_LSL: begin
                next_result = lsl_ext[31:0];
                next_carry  = lsl_ext[32];
            end
            OP_LSR: begin
                next_result = lsr_ext[32:1];
                next_carry  = lsr_ext[0];
            end
            OP_ASR: begin
                next_result = asr_ext[32:1];
                next_carry  = asr_ext[0];
            end
            OP_COPY: next_result = op_b;
            OP_PASS: next_result = op_a;
            default: next_result = '0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            alu_result    <= '0;
            alu_carry_out <= 1'b0;
            alu_zero_out  <= 1'b0;
            alu_neg_out   <= 1'b0;
            alu_over_out  <= 1'b0;
        end else begin
            alu_result    <= next_result;
            alu_carry_out <= next_carry;
            alu_zero_out  <= (next_result == 32'd0);
            alu_neg_out   <= next_result[31];
            alu_over_out  <= next_over;
        end
    end

    // ---------------- Bus interface ----------------
    logic       access_req;
    logic       misaligned;
    logic [3:0] lane_mask;
    logic [4:0] byte_shift;

    assign access_req  = cpu_read | cpu_write;
    assign bus_address = cpu_address[31:2];
    // Big-endian: address offset 0 is lane 3 (bits 31:24).
    assign byte_shift  = {3'b011 - {1'b0, cpu_address[1:0]}, 3'b000};

    always_comb begin
        misaligned   = 1'b0;
        lane_mask    = 4'b0000;
        bus_data_out = '0;
        cpu_data_in  = '0;
        case (cpu_cycle_width)
            WIDTH_BYTE: begin
                lane_mask    = 4'b1000 >> cpu_address[1:0];
                bus_data_out = {24'd0, cpu_data_out[7:0]} << byte_shift;
                cpu_data_in  = {24'd0, 8'(bus_data_in >> byte_shift)};
            end
            WIDTH_WORD: begin
                misaligned = cpu_address[0];
                if (cpu_address[1]) begin
                    lane_mask    = 4'b0011;
                    bus_data_out = {16'd0, cpu_data_out[15:0]};
                    cpu_data_in  = {16'd0, bus_data_in[15:0]};
                end else begin
                    lane_mask    = 4'b1100;
                    bus_data_out = {cpu_data_out[15:0], 16'd0};
                    cpu_data_in  = {16'd0, bus_data_in[31:16]};
                end
            end
            WIDTH_LONG: begin
                misaligned   = (cpu_address[1:0] != 2'b00);
                lane_mask    = 4'b1111;
                bus_data_out = cpu_data_out;
                cpu_data_in  = bus_data_in;
            end
            default: misaligned = 1'b1;
        endcase
    end

    assign bus_error        = access_req & misaligned;
    assign bus_data_strobes = (access_req & ~bus_error) ? lane_mask : 4'b0000;
    assign bus_write        = cpu_write & ~bus_error;
    assign bus_read         = cpu_read & ~cpu_write & ~bus_error;

endmodule

// File: tb/tb_maxicore32_exec_unit.sv
// Directed bench for maxicore32_exec_unit: ALU results go through a scoreboard queue,
// AGU and bus-interface outputs are checked directly against constants.
module tb_maxicore32_exec_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] agu_base_address, agu_register_data, agu_result;
    logic        agu_immediate_mode;
    logic [15:0] agu_immediate;
    logic [4:0]  alu_op;
    logic [31:0] alu_reg2, alu_reg3, alu_result;
    logic        alu_carry_in, alu_carry_out, alu_zero_out, alu_neg_out, alu_over_out;
    logic [31:0] cpu_address, cpu_data_out, cpu_data_in;
    logic [1:0]  cpu_cycle_width;
    logic        cpu_read, cpu_write;
    logic [29:0] bus_address;
    logic [31:0] bus_data_in, bus_data_out;
    logic [3:0]  bus_data_strobes;
    logic        bus_read, bus_write, bus_error;

    int checks = 0;
    int errors = 0;

    // Expected flags packed as {N, Z, C, V}.
    typedef struct {
        string       tag;
        logic [31:0] result;
        logic [3:0]  flags;
    } alu_exp_t;

    alu_exp_t scoreboard[$];

    maxicore32_exec_unit dut (
        .clock(clock), .reset(reset),
        .agu_base_address(agu_base_address), .agu_immediate_mode(agu_immediate_mode),
        .agu_immediate(agu_immediate), .agu_register_data(agu_register_data),
        .agu_result(agu_result),
        .alu_op(alu_op), .alu_reg2(alu_reg2), .alu_reg3(alu_reg3),
        .alu_carry_in(alu_carry_in), .alu_result(alu_result),
        .alu_carry_out(alu_carry_out), .alu_zero_out(alu_zero_out),
        .alu_neg_out(alu_neg_out), .alu_over_out(alu_over_out),
        .cpu_address(cpu_address), .cpu_cycle_width(cpu_cycle_width),
        .cpu_data_out(cpu_data_out), .cpu_data_in(cpu_data_in),
        .cpu_read(cpu_read), .cpu_write(cpu_write),
        .bus_address(bus_address), .bus_data_in(bus_data_in), .bus_data_out(bus_data_out),
        .bus_data_strobes(bus_data_strobes), .bus_read(bus_read), .bus_write(bus_write),
        .bus_error(bus_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Drive one op, queue its expectation, then compare after the edge.
    task automatic alu_step(input string tag, input logic [4:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic cin,
                            input logic [31:0] exp_result, input logic [3:0] exp_flags);
        alu_exp_t e;
        alu_op       = op;
        alu_reg2     = a;
        alu_reg3     = b;
        alu_carry_in = cin;
        scoreboard.push_back('{tag, exp_result, exp_flags});
        @(posedge clock);
        #1;
        checks++;
        assert (scoreboard.size() > 0) else begin
            errors++;
            $error("FAIL %s scoreboard empty observed=0x%08h expected=entry", tag, alu_result);
        end
        if (scoreboard.size() > 0) begin
            e = scoreboard.pop_front();
            check({e.tag, "_result"}, alu_result, e.result);
            check({e.tag, "_nzcv"}, {28'd0, alu_neg_out, alu_zero_out, alu_carry_out, alu_over_out},
                  {28'd0, e.flags});
        end
    endtask

    task automatic bus_drive(input logic [1:0] width, input logic [31:0] addr,
                             input logic rd, input logic wr, input logic [31:0] dout);
        cpu_cycle_width = width;
        cpu_address     = addr;
        cpu_read        = rd;
        cpu_write       = wr;
        cpu_data_out    = dout;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        agu_base_address = '0; agu_immediate_mode = 1'b0; agu_immediate = '0; agu_register_data = '0;
        alu_op = '0; alu_reg2 = '0; alu_reg3 = '0; alu_carry_in = 1'b0;
        cpu_address = '0; cpu_cycle_width = 2'b00; cpu_data_out = '0;
        cpu_read = 1'b0; cpu_write = 1'b0; bus_data_in = 32'h1122_3344;

        // Reset state, with a live op present that reset must override.
        alu_step("reset_init", 5'b00000, 32'd7, 32'd9, 1'b1, 32'd0, 4'b0000);
        alu_step("reset_add5", 5'b00000, 32'd5, 32'd5, 1'b0, 32'd0, 4'b0000);
        reset = 1'b0;
        alu_step("post_reset_add", 5'b00000, 32'd5, 32'd5, 1'b0, 32'h0000_000A, 4'b0000);

        // Add / subtract
        alu_step("add_ovf",   5'b00000, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 4'b1001);
        alu_step("add_carry", 5'b00000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 4'b1010);
        alu_step("addc_zero", 5'b00001, 32'hFFFF_FFFF, 32'd0, 1'b1, 32'd0, 4'b0110);
        alu_step("sub_neg",   5'b00010, 32'd1, 32'd2, 1'b0, 32'hFFFF_FFFF, 4'b1010);
        alu_step("sub_ovf",   5'b00010, 32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 4'b0001);
        alu_step("subc_nb",   5'b00011, 32'd5, 32'd3, 1'b1, 32'd1, 4'b0000);
        alu_step("subc_b",    5'b00011, 32'd3, 32'd3, 1'b1, 32'hFFFF_FFFF, 4'b1010);
        alu_step("neg_one",   5'b01100, 32'h1234_5678, 32'd1, 1'b0, 32'hFFFF_FFFF, 4'b1010);
        alu_step("neg_min",   5'b01100, 32'd0, 32'h8000_0000, 1'b0, 32'h8000_0000, 4'b1011);

        // Shifts
        alu_step("lsr_1",     5'b01001, 32'h0000_0003, 32'd1, 1'b0, 32'h0000_0001, 4'b0010);
        alu_step("asr_31",    5'b01010, 32'h8000_0000, 32'd31, 1'b0, 32'hFFFF_FFFF, 4'b1000);
        alu_step("lsl_1",     5'b01000, 32'h8000_0001, 32'd1, 1'b0, 32'h0000_0002, 4'b0010);
        alu_step("lsl_cnt0",  5'b01000, 32'h1234_5678, 32'h0000_0020, 1'b1, 32'h1234_5678, 4'b0000);

        // Logic, copy, pass, undefined (carry-in high must not leak into C)
        alu_step("and",       5'b00100, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'hF000_F000, 4'b1000);
        alu_step("or",        5'b00101, 32'h0000_00F0, 32'h0000_000F, 1'b1, 32'h0000_00FF, 4'b0000);
        alu_step("xor_zero",  5'b00110, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 32'd0, 4'b0100);
        alu_step("not",       5'b00111, 32'h1111_1111, 32'd0, 1'b1, 32'hFFFF_FFFF, 4'b1000);
        alu_step("copy",      5'b01011, 32'h1111_1111, 32'h0BAD_F00D, 1'b1, 32'h0BAD_F00D, 4'b0000);
        alu_step("pass",      5'b11111, 32'h8765_4321, 32'h0BAD_F00D, 1'b1, 32'h8765_4321, 4'b1000);
        alu_step("undef",     5'b01101, 32'h8765_4321, 32'h0BAD_F00D, 1'b1, 32'd0, 4'b0100);

        // AGU
        agu_base_address = 32'h0000_1000; agu_immediate_mode = 1'b1; agu_immediate = 16'hFFFC;
        agu_register_data = 32'h5555_5555;
        #1 check("agu_imm_neg", agu_result, 32'h0000_0FFC);
        agu_immediate = 16'h0004;
        #1 check("agu_imm_pos", agu_result, 32'h0000_1004);
        agu_base_address = 32'h0000_2000; agu_immediate_mode = 1'b0; agu_register_data = 32'hFFFF_F000;
        #1 check("agu_reg_wrap", agu_result, 32'h0000_1000);

        // Byte accesses
        bus_drive(2'b00, 32'h0000_0103, 1'b0, 1'b1, 32'h1234_56AB);
        check("bw103_addr", {2'b00, bus_address}, 32'h0000_0040);
        check("bw103_strb", {28'd0, bus_data_strobes}, 32'h1);
        check("bw103_data", bus_data_out, 32'h0000_00AB);
        check("bw103_ctl", {29'd0, bus_read, bus_write, bus_error}, 32'b010);
        bus_drive(2'b00, 32'h0000_0100, 1'b0, 1'b1, 32'h0000_00AB);
        check("bw100_strb", {28'd0, bus_data_strobes}, 32'h8);
        check("bw100_data", bus_data_out, 32'hAB00_0000);
        bus_drive(2'b00, 32'h0000_0100, 1'b1, 1'b0, 32'h0);
        check("br100_data", cpu_data_in, 32'h0000_0011);
        check("br100_ctl", {29'd0, bus_read, bus_write, bus_error}, 32'b100);
        bus_drive(2'b00, 32'h0000_0102, 1'b1, 1'b0, 32'h0);
        check("br102_data", cpu_data_in, 32'h0000_0033);
        check("br102_strb", {28'd0, bus_data_strobes}, 32'h2);

        // Word accesses
        bus_drive(2'b01, 32'h0000_0102, 1'b1, 1'b0, 32'h0);
        check("wr102_data", cpu_data_in, 32'h0000_3344);
        check("wr102_strb", {28'd0, bus_data_strobes}, 32'h3);
        bus_drive(2'b01, 32'h0000_0100, 1'b0, 1'b1, 32'hFFFF_BEEF);
        check("ww100_data", bus_data_out, 32'hBEEF_0000);
        check("ww100_strb", {28'd0, bus_data_strobes}, 32'hC);

        // Errors
        bus_drive(2'b01, 32'h0000_0101, 1'b1, 1'b0, 32'h0);
        check("wr101_ctl", {29'd0, bus_read, bus_write, bus_error}, 32'b001);
        check("wr101_strb", {28'd0, bus_data_strobes}, 32'h0);
        bus_drive(2'b10, 32'h0000_0202, 1'b0, 1'b1, 32'hCAFE_F00D);
        check("lw202_ctl", {29'd0, bus_read, bus_write, bus_error}, 32'b001);
        check("lw202_strb", {28'd0, bus_data_strobes}, 32'h0);
        bus_drive(2'b11, 32'h0000_0200, 1'b1, 1'b0, 32'h0);
        check("rsvd_ctl", {29'd0, bus_read, bus_write, bus_error}, 32'b001);
        bus_drive(2'b11, 32'h0000_0201, 1'b0, 1'b0, 32'h0);
        check("idle_ctl", {29'd0, bus_read, bus_write, bus_error}, 32'b000);
        check("idle_strb", {28'd0, bus_data_strobes}, 32'h0);

        // Long accesses
        bus_drive(2'b10, 32'h0000_0200, 1'b1, 1'b0, 32'h0);
        check("lr200_strb", {28'd0, bus_data_strobes}, 32'hF);
        check("lr200_ctl", {29'd0, bus_read, bus_write, bus_error}, 32'b100);
        check("lr200_data", cpu_data_in, 32'h1122_3344);
        check("lr200_addr", {2'b00, bus_address}, 32'h0000_0080);
        bus_drive(2'b10, 32'h0000_0200, 1'b1, 1'b1, 32'hCAFE_F00D);
        check("lrw200_ctl", {29'd0, bus_read, bus_write, bus_error}, 32'b010);
        check("lrw200_data", bus_data_out, 32'hCAFE_F00D);

        // Combinational paths ignore reset.
        reset = 1'b1;
        bus_drive(2'b00, 32'h0000_0101, 1'b1, 1'b0, 32'h0);
        check("rst_br101_data", cpu_data_in, 32'h0000_0022);
        check("rst_agu", agu_result, 32'h0000_1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
